// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative restoring divider for MIPS32 DIV/DIVU.
// Produces one quotient bit per clock. Quotient goes to LO and remainder to HI.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterative datapath.
//
// Timing, with the op accepted at edge k:
//   edges k+1 .. k+WIDTH : CALC, one quotient bit per edge
//   edge  k+WIDTH+1      : FIXUP applies the signs
//   edge  k+WIDTH+2      : DONE publishes quo/rem/div_zero and pulses done
// A new op is accepted on any edge where the state is IDLE or DONE, so
// back-to-back operations need no bubble.
module alu_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] prem;      // partial remainder
  logic [WIDTH-1:0] dvd;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] a_raw;     // raw dividend, returned as remainder on b==0
  logic             op_sign;
  logic             neg_a;
  logic             neg_b;
  logic             bz;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             bz_res;

  logic             b_zero_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   shifted_c;
  logic             ge_c;
  logic [WIDTH-1:0] diff_c;

  // Operand magnitudes used at accept time.
  assign b_zero_c = (b == '0);
  assign mag_a_c  = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b_c  = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // One shift-subtract step.
  // Because prem < dvs, a successful subtraction always fits in WIDTH bits.
  assign shifted_c = {prem, dvd[WIDTH-1]};
  assign ge_c      = (shifted_c >= {1'b0, dvs});
  assign diff_c    = shifted_c[WIDTH-1:0] - dvs;

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      prem     <= '0;
      dvd      <= '0;
      dvs      <= '0;
      a_raw    <= '0;
      op_sign  <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      bz       <= 1'b0;
      cnt      <= '0;
      q_res    <= '0;
      r_res    <= '0;
      bz_res   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            quo      <= q_res;
            rem      <= r_res;
            div_zero <= bz_res;
            done     <= 1'b1;
          end
          state <= IDLE;
          if (start) begin
            op_sign <= sign;
            neg_a   <= sign & a[WIDTH-1];
            neg_b   <= sign & b[WIDTH-1];
            a_raw   <= a;
            bz      <= b_zero_c;
            prem    <= '0;
            dvd     <= mag_a_c;
            dvs     <= mag_b_c;
            cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b_zero_c) begin
              q_res  <= '1;
              r_res  <= a;
              bz_res <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end
        end
        CALC: begin
          prem <= ge_c ? diff_c : shifted_c[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], ge_c};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (bz) begin
            q_res  <= '1;
            r_res  <= a_raw;
            bz_res <= 1'b1;
          end else begin
            q_res  <= (op_sign && (neg_a != neg_b)) ? (~dvd + WIDTH'(1)) : dvd;
            r_res  <= (op_sign && neg_a) ? (~prem + WIDTH'(1)) : prem;
            bz_res <= 1'b0;
          end
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Testbench for alu_div_seq.
// A queue-based reference model predicts done/busy timing and the results.
// The model uses plain signed/unsigned arithmetic.
module tb_alu_div_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sign = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic          div_zero;

  alu_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    int          due;
    bit          busy_op;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit          z;
  } exp_t;

  exp_t         expq[$];
  int           cyc = 0;
  int           free_at = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  bit           held_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics.
  // Division truncates toward zero, and the remainder takes the dividend's sign.
  function automatic void ref_div(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    z = (y == 0);
    if (z) begin
      q = '1;
      r = x;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = x;
        r = '0;
      end else begin
        q = 32'($signed(x) / $signed(y));
        r = 32'($signed(x) % $signed(y));
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Drive one cycle's inputs, 2ns after a rising edge, for the next edge.
  // Record the op in the model if the divider will accept it.
  task automatic drive_cycle(input bit st, input bit sg, input logic [W-1:0] aa,
                             input logic [W-1:0] bb);
    exp_t e;
    @(posedge clk);
    #2;
    start = st;
    sign  = sg;
    a     = aa;
    b     = bb;
    if (st && rst_n && (cyc + 1 >= free_at)) begin
      e.acc = cyc + 1;
      ref_div(sg, aa, bb, e.q, e.r, e.z);
`ifdef DIV_ZERO_FAST_EN
      if (e.z) begin
        e.due = e.acc + 1;
        e.busy_op = 1'b0;
      end else begin
        e.due = e.acc + W + 2;
        e.busy_op = 1'b1;
      end
`else
      e.due = e.acc + W + 2;
      e.busy_op = 1'b1;
`endif
      free_at = e.due;
      expq.push_back(e);
    end
  endtask

  // Check the DUT on every cycle: busy, done and results against the model.
  always @(negedge clk) begin : compare
    bit eb;
    bit ed;
    eb = 1'b0;
    foreach (expq[i])
      if (expq[i].busy_op && cyc >= expq[i].acc && cyc <= expq[i].acc + W) eb = 1'b1;
    ed = (expq.size() > 0) && (expq[0].due == cyc);
    chk("busy", W'(busy), W'(eb));
    chk("done", W'(done), W'(ed));
    if (ed) begin
      held_q = expq[0].q;
      held_r = expq[0].r;
      held_z = expq[0].z;
      void'(expq.pop_front());
    end
    chk("quo", quo, held_q);
    chk("rem", rem, held_r);
    chk("div_zero", W'(div_zero), W'(held_z));
  end

  // Directed op with literal expectations and latency.
  // inject_at >= 0 drives a stray start with other operands on that idle cycle.
  task automatic run_op(input string name, input bit s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input bit ez, input int lat,
                        input int inject_at);
    int  acc;
    bit  seen;
    drive_cycle(1'b1, s, x, y);
    acc  = cyc + 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (i == inject_at) drive_cycle(1'b1, ~s, 32'h1234_5678, 32'h0000_0003);
      else drive_cycle(1'b0, 1'b0, '0, '0);
      if (done) begin
        seen = 1'b1;
        chk({name, "_quo"}, quo, eq);
        chk({name, "_rem"}, rem, er);
        chk({name, "_dz"}, W'(div_zero), W'(ez));
        chk({name, "_lat"}, W'(cyc - acc), W'(lat));
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Pick operands that hit corner values often.
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: pick = '0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = W'($urandom_range(1, 16));
      4: pick = 32'h7FFF_FFFF;
      default: pick = $urandom;
    endcase
  endfunction

  int zlat;

  initial begin
`ifdef DIV_ZERO_FAST_EN
    zlat = 1;
`else
    zlat = W + 2;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 2, -1);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W + 2, -1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, W + 2, -1);
    run_op("divu_bz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, zlat, -1);
    run_op("div_bz", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, zlat, -1);
    run_op("div_a0", 1'b1, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b0, W + 2, -1);
    run_op("div_ign", 1'b1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, 1'b0, W + 2, 10);
    // Issued while done is high: must be accepted immediately.
    run_op("divu_b2b", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, W + 2, -1);

    // Reset at iteration 10 discards the op and clears outputs at once.
    drive_cycle(1'b1, 1'b0, 32'd12345, 32'd11);
    repeat (10) drive_cycle(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expq.delete();
    free_at = 0;
    held_q = '0;
    held_r = '0;
    held_z = 1'b0;
    #1;
    chk("rst_quo", quo, '0);
    chk("rst_rem", rem, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    repeat (2) drive_cycle(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, W + 2, -1);

    // Random traffic, including back-to-back starts and starts while busy.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), pick(), pick());
    end
    repeat (W + 6) drive_cycle(1'b0, 1'b0, '0, '0);
    if (expq.size() != 0) chk("drain", W'(expq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
